seq_serializer: RTL
===================

// Module: seq_serializer
// PURPOSE
//   Parallel-to-serial bit source feeding the sequence detector's serial input (din).
//   Accepts W-bit words over a valid/ready handshake and shifts them out one bit per clock.
//   A one-word holding buffer gives gapless back-to-back streaming.
//   A pause input freezes the shifter; a synchronous flush discards all pending data.
// PARAMETERS
//   W          8   word width in bits (>=2)
//   MSB_FIRST  1   1: bit W-1 goes out first; 0: bit 0 goes out first
//   IDLE_LEVEL 0   value driven on sout when no word is being shifted
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active-low
//   flush      in   1    synchronous clear of shifter and holding buffer
//   pause      in   1    1 = hold current bit; no shift, no bit-count advance
//   in_data    in   W    parallel word
//   in_valid   in   1    in_data valid
//   in_ready   out  1    block can accept a word this cycle
//   sout       out  1    serial bit to the detector's din
//   sout_valid out  1    sout carries a data bit this cycle
//   busy       out  1    shifter or holding buffer holds data
// BEHAVIOUR
//   Reset (rst=0, async) and flush (sync, highest priority over all other events):
//     sout=IDLE_LEVEL, sout_valid=0, in_ready=1, busy=0.
//     Bit count=0; shifter and holding buffer empty.
//     A word offered in the flush cycle is NOT accepted.
//   Handshake:
//     Word accepted on the rising edge where in_valid && in_ready.
//     in_ready = !hold_full (registered state; combinational from state only, not from in_valid).
//   States:
//     IDLE: shifter empty. Accepted word loads the shifter directly -> SHIFT.
//       First bit appears on sout with sout_valid=1 in the cycle after the accepting edge (latency 1).
//     SHIFT: each edge with pause=0 advances one bit; bit count 0..W-1.
//       - Word accepted mid-word (count < W-1): stored in the holding buffer; in_ready drops next cycle.
//       - Last-bit edge (count = W-1, pause=0), in priority order:
//           (a) hold full: hold -> shifter, hold empties, in_ready=1 next cycle.
//           (b) hold empty and a word is accepted at this edge: word -> shifter directly.
//           (c) otherwise: -> IDLE; sout=IDLE_LEVEL and sout_valid=0 next cycle.
//         In (a)/(b) the next word's first bit follows with no gap.
//   Pause:
//     sout, sout_valid and the count are held.
//     The handshake still runs (the hold buffer may fill).
//     Pause in IDLE has no visible effect.
//   Bit order: MSB_FIRST=1 gives in_data[W-1] first, [0] last; 0 gives the reverse.
//   busy = (state==SHIFT) || hold_full.
//   All outputs registered except in_ready. No combinational path from in_valid to any output.
//   Reset asserted mid-word: bits not yet sent are lost; no partial output after release.
// TESTING
//   1. Reset: rst=0 with in_valid=1 -> sout=0, sout_valid=0, in_ready=1, busy=0; nothing accepted.
//   2. Single word: W=8, MSB_FIRST=1, in_data=8'b0100_1010 for 1 cycle
//      -> sout = 0,1,0,0,1,0,1,0 over 8 cycles with sout_valid=1, then sout_valid=0 and busy=0.
//   3. Back-to-back: in_valid held high with words 8'hA5, 8'h3C
//      -> 16 contiguous valid bits, no gap; in_ready low while the hold buffer is full.
//   4. Pause: pause=1 for 3 cycles during bit 4 -> bit 4 is held 4 cycles total;
//      the word completes 3 cycles late with the same bit order.
//   5. Flush and reset mid-word: flush at bit 2 with the hold buffer full
//      -> next cycle sout_valid=0, in_ready=1, busy=0.
//      rst pulse at bit 5 -> same reset values.
//   6. LSB-first: MSB_FIRST=0, 8'h01 -> sout = 1,0,0,0,0,0,0,0.
//      End-to-end: stream repeated 3'b010 patterns into seq_detect; its dout pulses once per detected pattern.

Source files
------------

// File: rtl/seq_serializer_if.sv
// Word handshake between a parallel source and seq_serializer.
interface seq_serializer_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  // Source side drives the word; serializer answers with ready.
  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial bit source: W-bit words in over valid/ready, one bit per clock out.
// A one-word holding buffer lets the next word follow the current one with no gap.
module seq_serializer #(
  parameter int unsigned W          = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              pause,
  seq_serializer_if.slave   bus,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q;
  logic [W-1:0]    shreg_q;
  logic [W-1:0]    hold_q;
  logic            hold_full_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic [W-1:0]    shreg_nxt;

  // Bit that goes out first for a freshly loaded (or freshly shifted) register.
  function automatic logic first_bit(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  // Ready depends on registered state only; flush blocks acceptance.
  assign bus.in_ready = !hold_full_q;
  assign accept       = bus.in_valid && !hold_full_q && !flush;
  assign shreg_nxt    = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
  assign busy         = (state_q == StShift) || hold_full_q;

  // Shifter FSM: loads, shifts, hold-buffer handoff and registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      sout        <= IDLE_LEVEL;
      sout_valid  <= 1'b0;
    end else if (flush) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      sout        <= IDLE_LEVEL;
      sout_valid  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q    <= bus.in_data;
            sout       <= first_bit(bus.in_data);
            sout_valid <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          if (!pause && (cnt_q == LastCnt)) begin
            // Word boundary: hold buffer wins, then a word accepted now, else go idle.
            cnt_q <= '0;
            if (hold_full_q) begin
              shreg_q     <= hold_q;
              sout        <= first_bit(hold_q);
              hold_full_q <= 1'b0;
            end else if (accept) begin
              shreg_q <= bus.in_data;
              sout    <= first_bit(bus.in_data);
            end else begin
              state_q    <= StIdle;
              sout       <= IDLE_LEVEL;
              sout_valid <= 1'b0;
            end
          end else begin
            if (!pause) begin
              shreg_q <= shreg_nxt;
              sout    <= first_bit(shreg_nxt);
              cnt_q   <= cnt_q + CW'(1);
            end
            // Handshake keeps running while paused.
            if (accept) begin
              hold_q      <= bus.in_data;
              hold_full_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
